// File: rtl/seg7_scan_ctrl_0_2_pkg.sv
// seg7_scan_ctrl_0_2_pkg
// Shared constants for the 0-2 seven-segment scan controller:
//   SEG_0/SEG_1/SEG_2/SEG_OFF - active-low segment patterns, bit order gfedcba
//   DIG_BLANK                 - digit code that shows nothing
//   scan_state_e              - slot phase (ST_BLANK / ST_SHOW)
package seg7_scan_ctrl_0_2_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [1:0] DIG_BLANK = 2'b11;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_0_2_if.sv
// seg7_scan_ctrl_0_2_if
// Valid/ready update channel carrying a full set of display digits.
//   upd_valid - producer has new digits
//   upd_data  - 2 bits per digit, digit i at [2i+1:2i]
//   upd_ready - consumer can take a new set of digits
// master = value producer, slave = scan controller.
interface seg7_scan_ctrl_0_2_if #(
  parameter int N_DIGITS = 4
);

  logic                    upd_valid;
  logic [2*N_DIGITS-1:0]   upd_data;
  logic                    upd_ready;

  modport master (
    output upd_valid,
    output upd_data,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_data,
    output upd_ready
  );

endinterface

// File: rtl/seg7_scan_ctrl_0_2_dec.sv
// num_to_seg7_0_2
// Combinational decoder from a 2-bit digit code to active-low segments.
//   num_i - digit code, 0..2 shown, 3 blank
//   seg_o - segments gfedcba, active-low
module num_to_seg7_0_2
  import seg7_scan_ctrl_0_2_pkg::*;
(
  input  logic [1:0] num_i,
  output logic [6:0] seg_o
);

  // Code 3 falls through to the all-off pattern.
  always_comb begin
    seg_o = SEG_OFF;
    case (num_i)
      2'd0:    seg_o = SEG_0;
      2'd1:    seg_o = SEG_1;
      2'd2:    seg_o = SEG_2;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl_0_2.sv
// seg7_scan_ctrl_0_2
// Time-multiplexed driver for N_DIGITS common-anode 7-segment digits.
// Each digit slot is BLANK_CYC cycles dark followed by SCAN_DIV-BLANK_CYC
// lit cycles. New digits arrive over a valid/ready channel and are swapped
// into the displayed set only at the end of a full frame.
//   clk         - system clock, rising edge
//   rst_n       - synchronous active-low reset
//   upd         - update channel (slave side)
//   an          - anode enables, active-low, an[0] = digit 0
//   seg7        - segments gfedcba, active-low
//   dpt         - decimal point, active-low, held off
//   frame_start - one-cycle pulse on the first blank cycle of digit 0
module seg7_scan_ctrl_0_2
  import seg7_scan_ctrl_0_2_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg7_scan_ctrl_0_2_if.slave     upd,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg7,
  output logic                    dpt,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(N_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*N_DIGITS-1:0]   active_q, active_d;
  logic [2*N_DIGITS-1:0]   pend_buf_q, pend_buf_d;
  logic                    pend_q, pend_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [6:0]              seg7_q, seg7_d;
  logic                    dpt_q;
  logic                    fs_q, fs_d;
  logic                    boundary;
  logic [1:0]              cur_digit;
  logic [6:0]              dec_seg;

  assign cur_digit = active_q[{idx_q, 1'b0} +: 2];

  num_to_seg7_0_2 u_dec (
    .num_i (cur_digit),
    .seg_o (dec_seg)
  );

  // Ready stays high while reset is held so the producer never sees a
  // stale pending flag before the first reset edge.
  assign upd.upd_ready = ~pend_q | ~rst_n;

  // Registers for the scan sequence, the buffers and the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      idx_q      <= '0;
      cnt_q      <= '0;
      active_q   <= {N_DIGITS{DIG_BLANK}};
      pend_buf_q <= '0;
      pend_q     <= 1'b0;
      an_q       <= '1;
      seg7_q     <= SEG_OFF;
      dpt_q      <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pend_buf_q <= pend_buf_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg7_q     <= seg7_d;
      dpt_q      <= 1'b1;
      fs_q       <= fs_d;
    end
  end

  // Next-state: slot sequencing, frame-boundary commit, update acceptance,
  // and the output values derived from the current state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + 1'b1;
    boundary   = 1'b0;
    active_d   = active_q;
    pend_buf_d = pend_buf_q;
    pend_d     = pend_q;
    an_d       = '1;
    seg7_d     = SEG_OFF;
    fs_d       = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_BLANK_LAST) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = ST_BLANK;
          boundary = (idx_q == IDX_LAST);
          idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // Commit and accept are exclusive: accepting needs pend_q low and
    // committing needs it high, so a boundary-cycle accept waits a frame.
    if (boundary && pend_q) begin
      active_d = pend_buf_q;
      pend_d   = 1'b0;
    end else if (upd.upd_valid && !pend_q) begin
      pend_buf_d = upd.upd_data;
      pend_d     = 1'b1;
    end

    if (state_q == ST_SHOW) begin
      an_d[idx_q] = 1'b0;
      seg7_d      = dec_seg;
    end
  end

  assign an          = an_q;
  assign seg7        = seg7_q;
  assign dpt         = dpt_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl_0_2.sv
// tb_seg7_scan_ctrl_0_2
// Directed self-checking bench for seg7_scan_ctrl_0_2 with N_DIGITS=4,
// SCAN_DIV=8, BLANK_CYC=2 (32-cycle frames). Outputs are sampled on the
// falling edge; inputs change on the falling edge or just after a rising one.
module tb_seg7_scan_ctrl_0_2;

  logic       clk;
  logic       rstN;
  logic [3:0] an;
  logic [6:0] seg7;
  logic       dpt;
  logic       frameStart;

  int testsRun;
  int testsFailed;

  seg7_scan_ctrl_0_2_if #(.N_DIGITS(4)) updIf ();

  seg7_scan_ctrl_0_2 #(
    .N_DIGITS  (4),
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .upd         (updIf),
    .an          (an),
    .seg7        (seg7),
    .dpt         (dpt),
    .frame_start (frameStart)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected segment pattern for one digit code.
  function automatic logic [6:0] segOf(input logic [1:0] v);
    case (v)
      2'd0:    return 7'b1000000;
      2'd1:    return 7'b1111001;
      2'd2:    return 7'b0100100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected anodes at a cycle offset from the frame_start cycle.
  function automatic logic [3:0] expAn(input int off);
    int slot = (off % 32) / 8;
    int pos  = off % 8;
    logic [3:0] one = 4'b0001;
    if (pos < 2) return 4'hF;
    return ~(one << slot);
  endfunction

  // Expected segments at a cycle offset for a given set of digits.
  function automatic logic [6:0] expSeg(input int off, input logic [7:0] data);
    int slot = (off % 32) / 8;
    int pos  = off % 8;
    if (pos < 2) return 7'h7F;
    return segOf(data[2*slot +: 2]);
  endfunction

  // Advance to the next falling edge that shows frame_start, bounded.
  task automatic waitFrame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frameStart === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    updIf.upd_valid = 1'b0;
    updIf.upd_data  = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      testsRun++;
      if (an !== 4'hF || seg7 !== 7'h7F || dpt !== 1'b1 || updIf.upd_ready !== 1'b1 || frameStart !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold c=%0d an=%h seg7=%h dpt=%b rdy=%b fs=%b expected an=f seg7=7f dpt=1 rdy=1 fs=0",
                 c, an, seg7, dpt, updIf.upd_ready, frameStart);
      end
    end
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    testsRun++;
    if (an !== 4'hF || seg7 !== 7'h7F || dpt !== 1'b1 || frameStart !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_first_cycle an=%h seg7=%h dpt=%b fs=%b expected an=f seg7=7f dpt=1 fs=0",
               an, seg7, dpt, frameStart);
    end
    for (int off = 0; off < 32; off++) begin
      @(negedge clk);
      testsRun++;
      if (frameStart !== (off == 0) || an !== expAn(off) || seg7 !== 7'h7F || dpt !== 1'b1 || updIf.upd_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL reset_first_frame off=%0d fs=%b an=%b seg7=%b rdy=%b expected fs=%b an=%b seg7=1111111 rdy=1",
                 off, frameStart, an, seg7, updIf.upd_ready, (off == 0), expAn(off));
      end
    end
  endtask

  task automatic test_load;
    bit ok;
    logic [7:0] data = 8'b10_01_00_10;
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL load_sync frame_start=0 expected 1 within 80 cycles");
    end
    updIf.upd_valid = 1'b1;
    updIf.upd_data  = data;
    @(negedge clk);
    updIf.upd_valid = 1'b0;
    testsRun++;
    if (updIf.upd_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL load_pending rdy=%b expected 0", updIf.upd_ready);
    end
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL load_frame frame_start=0 expected 1 within 80 cycles");
    end
    for (int off = 0; off < 32; off++) begin
      if (off > 0) @(negedge clk);
      testsRun++;
      if (frameStart !== (off == 0) || an !== expAn(off) || seg7 !== expSeg(off, data) || dpt !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL load off=%0d fs=%b an=%b seg7=%b dpt=%b expected fs=%b an=%b seg7=%b dpt=1",
                 off, frameStart, an, seg7, dpt, (off == 0), expAn(off), expSeg(off, data));
      end
    end
  endtask

  task automatic test_value3;
    bit ok;
    logic [7:0] data = 8'b10_01_11_10;
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL value3_sync frame_start=0 expected 1 within 80 cycles");
    end
    updIf.upd_valid = 1'b1;
    updIf.upd_data  = data;
    @(negedge clk);
    updIf.upd_valid = 1'b0;
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL value3_frame frame_start=0 expected 1 within 80 cycles");
    end
    for (int off = 0; off < 32; off++) begin
      if (off > 0) @(negedge clk);
      testsRun++;
      if (an !== expAn(off) || seg7 !== expSeg(off, data)) begin
        testsFailed++;
        $display("[TB] FAIL value3 off=%0d an=%b seg7=%b expected an=%b seg7=%b",
                 off, an, seg7, expAn(off), expSeg(off, data));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] dataA = 8'b00_01_10_00;
    logic [7:0] dataB = 8'b01_10_00_11;
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL b2b_sync frame_start=0 expected 1 within 80 cycles");
    end
    updIf.upd_valid = 1'b1;
    updIf.upd_data  = dataA;
    @(negedge clk);
    updIf.upd_data = dataB;
    testsRun++;
    if (updIf.upd_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_ready k=1 rdy=%b expected 0", updIf.upd_ready);
    end
    for (int k = 2; k <= 31; k++) begin
      @(negedge clk);
      testsRun++;
      if (updIf.upd_ready !== (k == 31)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_ready k=%0d rdy=%b expected %b", k, updIf.upd_ready, (k == 31));
      end
    end
    @(negedge clk);
    testsRun++;
    if (frameStart !== 1'b1 || updIf.upd_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_accept fs=%b rdy=%b expected fs=1 rdy=0", frameStart, updIf.upd_ready);
    end
    updIf.upd_valid = 1'b0;
    for (int off = 0; off < 32; off++) begin
      if (off > 0) @(negedge clk);
      testsRun++;
      if (an !== expAn(off) || seg7 !== expSeg(off, dataA)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_first off=%0d an=%b seg7=%b expected an=%b seg7=%b",
                 off, an, seg7, expAn(off), expSeg(off, dataA));
      end
    end
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second_sync frame_start=0 expected 1 within 80 cycles");
    end
    for (int off = 0; off < 32; off++) begin
      if (off > 0) @(negedge clk);
      testsRun++;
      if (an !== expAn(off) || seg7 !== expSeg(off, dataB)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_second off=%0d an=%b seg7=%b expected an=%b seg7=%b",
                 off, an, seg7, expAn(off), expSeg(off, dataB));
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [7:0] shown = 8'b01_10_00_11;
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_sync frame_start=0 expected 1 within 80 cycles");
    end
    updIf.upd_valid = 1'b1;
    updIf.upd_data  = 8'b00_00_00_00;
    @(negedge clk);
    updIf.upd_valid = 1'b0;
    testsRun++;
    if (updIf.upd_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_pending rdy=%b expected 0", updIf.upd_ready);
    end
    repeat (19) @(negedge clk);
    testsRun++;
    if (an !== 4'b1011 || seg7 !== expSeg(20, shown)) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_show an=%b seg7=%b expected an=1011 seg7=%b", an, seg7, expSeg(20, shown));
    end
    rstN = 1'b0;
    @(negedge clk);
    testsRun++;
    if (an !== 4'hF || seg7 !== 7'h7F || dpt !== 1'b1 || frameStart !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_blank an=%h seg7=%h dpt=%b fs=%b expected an=f seg7=7f dpt=1 fs=0",
               an, seg7, dpt, frameStart);
    end
    @(negedge clk);
    testsRun++;
    if (updIf.upd_ready !== 1'b1 || an !== 4'hF) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_ready rdy=%b an=%h expected rdy=1 an=f", updIf.upd_ready, an);
    end
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    testsRun++;
    if (an !== 4'hF || seg7 !== 7'h7F || frameStart !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_first_cycle an=%h seg7=%h fs=%b expected an=f seg7=7f fs=0", an, seg7, frameStart);
    end
    for (int off = 0; off < 64; off++) begin
      @(negedge clk);
      testsRun++;
      if (frameStart !== ((off % 32) == 0) || an !== expAn(off) || seg7 !== 7'h7F || updIf.upd_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL rstmid_after off=%0d fs=%b an=%b seg7=%b rdy=%b expected fs=%b an=%b seg7=1111111 rdy=1",
                 off, frameStart, an, seg7, updIf.upd_ready, ((off % 32) == 0), expAn(off));
      end
    end
  endtask

  task automatic test_frame_period;
    bit ok;
    waitFrame(ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL period_sync frame_start=0 expected 1 within 80 cycles");
    end
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      testsRun++;
      if (frameStart !== ((k % 32) == 0)) begin
        testsFailed++;
        $display("[TB] FAIL period k=%0d fs=%b expected %b", k, frameStart, ((k % 32) == 0));
      end
      testsRun++;
      if ($countones(~an) > 1) begin
        testsFailed++;
        $display("[TB] FAIL anode_onehot k=%0d an=%b expected at most one bit low", k, an);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rstN        = 1'b0;
    updIf.upd_valid = 1'b0;
    updIf.upd_data  = 8'h00;
    test_reset();
    test_load();
    test_value3();
    test_back_to_back();
    test_reset_mid();
    test_frame_period();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
